// File: rtl/grid_word_serializer.sv
// Serializes one lattice image into a stream of fixed-width words, most significant word first,
// zero-padding the first word so the inbound packer reconstructs the image exactly.
module grid_word_serializer #(
  parameter int GRID_BITS  = 2500,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [GRID_BITS-1:0]  grid_in,
  input  logic                  grid_valid,
  output logic                  grid_ready,
  input  logic                  abort,
  output logic [WORD_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int NUM_WORDS = (GRID_BITS + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int SHREG_W   = NUM_WORDS * WORD_WIDTH;
  localparam int CNT_W     = $clog2(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [SHREG_W-1:0]   r_shreg;
  logic [CNT_W-1:0]     r_word_cnt;
  logic                 r_frame_done;
  logic                 w_accept;
  logic                 w_handshake;
  logic                 w_last_handshake;

  assign w_accept         = (r_state == ST_IDLE) && grid_valid;
  assign w_handshake      = (r_state == ST_SEND) && m_ready;
  assign w_last_handshake = w_handshake && (r_word_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // abort wins over any acceptance or handshake in the same cycle
  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept)         w_next_state = ST_SEND;
        ST_SEND: if (w_last_handshake) w_next_state = ST_IDLE;
        default:                       w_next_state = ST_IDLE;
      endcase
    end
  end

  // Image is zero-extended on load so the padding lands in the top of word 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg      <= '0;
      r_word_cnt   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last_handshake && !abort;
      if (abort) begin
        r_word_cnt <= '0;
      end else if (w_accept) begin
        r_shreg    <= SHREG_W'(grid_in);
        r_word_cnt <= '0;
      end else if (w_handshake) begin
        r_shreg    <= r_shreg << WORD_WIDTH;
        r_word_cnt <= w_last_handshake ? '0 : r_word_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    grid_ready = 1'b0;
    m_valid    = 1'b0;
    m_data     = '0;
    m_last     = 1'b0;
    busy       = 1'b0;
    case (r_state)
      ST_IDLE: grid_ready = 1'b1;
      ST_SEND: begin
        m_valid = 1'b1;
        busy    = 1'b1;
        m_data  = r_shreg[SHREG_W-1 -: WORD_WIDTH];
        m_last  = (r_word_cnt == LAST_CNT);
      end
      default: grid_ready = 1'b1;
    endcase
  end

  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_grid_word_serializer.sv
// Bench for grid_word_serializer: a frame-level model plus an inbound-packer reconstruction,
// checked every cycle, with directed frames covering backpressure, back-to-back, abort and reset.
module tb_grid_word_serializer;

  localparam int GB = 2500;
  localparam int NW = 79;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [GB-1:0] grid_in;
  logic          grid_valid;
  logic          grid_ready;
  logic          abort;
  logic [31:0]   m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          frame_done;
  logic          busy;

  grid_word_serializer dut (
    .clk(clk), .rst_n(rst_n), .grid_in(grid_in), .grid_valid(grid_valid),
    .grid_ready(grid_ready), .abort(abort), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word k holds padded-image bits 2527-32k down to 2496-32k; bits at or above GB are padding
  function automatic logic [31:0] wordOf(input logic [GB-1:0] img, input int k);
    logic [31:0] w;
    int p;
    for (int j = 0; j < 32; j++) begin
      p = 2527 - 32 * k - (31 - j);
      w[j] = (p < GB) ? img[p] : 1'b0;
    end
    return w;
  endfunction

  function automatic logic [GB-1:0] randImg();
    logic [GB-1:0] v;
    for (int i = 0; i < GB; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Frame-level model: which image is in flight and which word should be on the bus
  logic          mBusy = 1'b0;
  int            mIdx = 0;
  logic          mDone = 1'b0;
  logic [GB-1:0] mImg = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBusy = 1'b0; mIdx = 0; mDone = 1'b0;
    end else begin
      mDone = 1'b0;
      if (abort) begin
        mBusy = 1'b0; mIdx = 0;
      end else if (!mBusy && grid_valid) begin
        mImg = grid_in; mBusy = 1'b1; mIdx = 0;
      end else if (mBusy && m_ready) begin
        if (mIdx == NW - 1) begin
          mBusy = 1'b0; mIdx = 0; mDone = 1'b1;
        end else mIdx++;
      end
    end
  end

  int          cycle = 0;
  int          rxCount = 0;
  logic [31:0] obsWords [NW];
  int          lastCount = 0;
  int          doneCount = 0;
  int          doneCyc = 0;
  int          acceptCyc [$];
  logic        prevStall = 1'b0;
  logic [31:0] prevData = '0;
  logic        prevLast = 1'b0;
  logic [2527:0] pad;

  always @(negedge clk) begin
    cycle++;
    checkOutput("grid_ready", grid_ready, !mBusy);
    checkOutput("m_valid", m_valid, mBusy);
    checkOutput("m_data", m_data, mBusy ? wordOf(mImg, mIdx) : 32'h0);
    checkOutput("m_last", m_last, mBusy && (mIdx == NW - 1));
    checkOutput("frame_done", frame_done, mDone);
    checkOutput("busy", busy, mBusy);
    if (prevStall && rst_n) begin
      checkOutput("stall m_valid", m_valid, 1'b1);
      checkOutput("stall m_data", m_data, prevData);
      checkOutput("stall m_last", m_last, prevLast);
    end
    if (rst_n && !abort && grid_valid && grid_ready) acceptCyc.push_back(cycle);
    if (!rst_n || abort) begin
      rxCount = 0;
    end else if (m_valid && m_ready) begin
      if (rxCount < NW) obsWords[rxCount] = m_data;
      if (m_last) begin
        lastCount++;
        checkOutput("words at m_last", rxCount, NW - 1);
        // Inbound packer view: words concatenated MSW first, top padding stripped
        for (int k = 0; k < NW; k++) pad[2527 - 32 * k -: 32] = obsWords[k];
        checkOutput("packer padding", pad[2527:GB], 0);
        checkOutput("packer image", pad[GB-1:0] == mImg, 1'b1);
        rxCount = 0;
      end else rxCount++;
    end
    if (frame_done) begin doneCount++; doneCyc = cycle; end
    prevStall = rst_n && !abort && m_valid && !m_ready;
    prevData  = m_data;
    prevLast  = m_last;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input logic [GB-1:0] img);
    grid_in = img; grid_valid = 1'b1;
    tick();
    grid_valid = 1'b0;
  endtask

  task automatic waitDone(input logic backpressure);
    int n = 0;
    while (!frame_done && n < 2000) begin
      if (backpressure) m_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    m_ready = 1'b1;
    checkOutput("frame_done timeout", frame_done, 1'b1);
  endtask

  task automatic waitWord(input int idx);
    int n = 0;
    while (rxCount != idx && n < 500) begin tick(); n++; end
    checkOutput("reach word timeout", rxCount, idx);
  endtask

  logic [GB-1:0] altImg;
  logic [GB-1:0] onesImg;
  int            d0;
  int            a0;

  initial begin
    for (int i = 0; i < GB; i++) altImg[i] = 1'(i % 2);
    onesImg = '1;
    rst_n = 1'b0; abort = 1'b0; m_ready = 1'b1;
    grid_valid = 1'b1; grid_in = randImg();

    checkOutput("model alt word0", wordOf(altImg, 0), 32'h0000000A);
    checkOutput("model alt word1", wordOf(altImg, 1), 32'hAAAAAAAA);
    checkOutput("model ones word0", wordOf(onesImg, 0), 32'h0000000F);
    checkOutput("model ones word78", wordOf(onesImg, 78), 32'hFFFFFFFF);

    repeat (4) tick();
    checkOutput("reset grid_ready", grid_ready, 1'b1);
    checkOutput("reset m_valid", m_valid, 1'b0);
    checkOutput("reset frame_done", frame_done, 1'b0);
    grid_valid = 1'b0; rst_n = 1'b1;
    tick();

    $display("[TB] alternating pattern frame");
    a0 = acceptCyc.size();
    d0 = lastCount;
    applyStimulus(altImg);
    waitDone(1'b0);
    checkOutput("alt ready after done", grid_ready, 1'b1);
    checkOutput("alt word0", obsWords[0], 32'h0000000A);
    checkOutput("alt word1", obsWords[1], 32'hAAAAAAAA);
    checkOutput("alt word78", obsWords[78], 32'hAAAAAAAA);
    checkOutput("alt m_last count", lastCount - d0, 1);
    tick();
    checkOutput("alt done period", doneCyc - acceptCyc[a0], 80);
    checkOutput("alt done one cycle", frame_done, 1'b0);

    $display("[TB] random backpressure frames");
    for (int f = 0; f < 2; f++) begin
      applyStimulus(randImg());
      waitDone(1'b1);
      tick();
    end

    $display("[TB] back-to-back frames");
    a0 = acceptCyc.size();
    grid_in = onesImg; grid_valid = 1'b1;
    tick();
    grid_in = altImg;
    waitDone(1'b0);
    tick();
    grid_valid = 1'b0; grid_in = randImg();
    waitDone(1'b0);
    checkOutput("b2b accept count", acceptCyc.size() - a0, 2);
    if (acceptCyc.size() - a0 >= 2)
      checkOutput("b2b period", acceptCyc[a0 + 1] - acceptCyc[a0], 80);
    checkOutput("b2b second word0", obsWords[0], 32'h0000000A);
    tick();

    $display("[TB] abort at word 40");
    d0 = doneCount;
    applyStimulus(randImg());
    waitWord(40);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort m_valid", m_valid, 1'b0);
    checkOutput("abort grid_ready", grid_ready, 1'b1);
    repeat (3) tick();
    checkOutput("abort no frame_done", doneCount - d0, 0);
    applyStimulus(altImg);
    waitDone(1'b0);
    checkOutput("post-abort word0", obsWords[0], 32'h0000000A);
    tick();

    $display("[TB] reset at word 10");
    applyStimulus(onesImg);
    waitWord(10);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async grid_ready", grid_ready, 1'b1);
    checkOutput("async m_valid", m_valid, 1'b0);
    checkOutput("async m_data", m_data, 32'h0);
    checkOutput("async m_last", m_last, 1'b0);
    checkOutput("async frame_done", frame_done, 1'b0);
    checkOutput("async busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(onesImg);
    waitDone(1'b1);
    checkOutput("post-reset word0", obsWords[0], 32'h0000000F);
    checkOutput("post-reset word78", obsWords[78], 32'hFFFFFFFF);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
